// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the Booth multiplier scheduler.
//   state_e  : scheduler FSM encoding (IDLE/ISSUE/WAIT/RESP, 2 bits)
//   DEF_*    : default parameter values for requester count, operand width,
//              and watchdog limit
//   prod_w() : product width for a given operand width (2*W, two's complement)
//   idx_w()  : width of a requester index, at least one bit
// -----------------------------------------------------------------------------
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam int DEF_N       = 4;
   localparam int DEF_W       = 4;
   localparam int DEF_TIMEOUT = 32;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/booth_mul_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. It searches upward from ptr_i,
// wrapping from N-1 to 0, and returns the first set request.
// Ports:
//   req_i  [N]   request vector
//   ptr_i  [IW]  highest-priority index for this search
//   gnt_o  [N]   one-hot grant (all zero when no request)
//   idx_o  [IW]  index of the granted request
//   any_o        at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
   import booth_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   int            pos;
   logic [IW-1:0] pos_idx;
   logic          found;

   // Visit the positions in priority order. The first hit wins, and later
   // hits are masked by the found flag.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found   = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr_i) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         pos_idx = IW'(pos);
         if (!found && req_i[pos_idx]) begin
            found          = 1'b1;
            gnt_o[pos_idx] = 1'b1;
            idx_o          = pos_idx;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/booth_mul_sched.sv
// -----------------------------------------------------------------------------
// booth_mul_sched
// Round-robin scheduler that shares one start/done signed multiplier among N
// requesters. Only one operation is in flight at a time.
// Ports:
//   clk_i, rst_i          clock (rising edge) and asynchronous active-high reset
//   req_valid_i  [N]      requester i has an operand pair
//   req_a_i/req_b_i [N*W] signed operands; requester i occupies [i*W +: W]
//   req_ready_o  [N]      one-hot accept strobe (IDLE only, combinational)
//   resp_valid_o [N]      one-hot one-cycle result strobe to the requester
//   resp_res_o   [2W]     signed product, qualified by resp_valid_o
//   resp_err_o            watchdog abort (resp_res_o is then 0)
//   busy_o                FSM is not in IDLE
//   mul_a_o/mul_b_o [W]   operands to the multiplier, held from ISSUE to WAIT
//   mul_start_o           one-cycle start pulse
//   mul_res_i    [2W]     multiplier product
//   mul_done_i            multiplier completion (pulse or level)
// -----------------------------------------------------------------------------
module booth_mul_sched
   import booth_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int W       = DEF_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req_valid_i,
   input  logic [N*W-1:0]       req_a_i,
   input  logic [N*W-1:0]       req_b_i,
   output logic [N-1:0]         req_ready_o,
   output logic [N-1:0]         resp_valid_o,
   output logic [prod_w(W)-1:0] resp_res_o,
   output logic                 resp_err_o,
   output logic                 busy_o,
   output logic [W-1:0]         mul_a_o,
   output logic [W-1:0]         mul_b_o,
   output logic                 mul_start_o,
   input  logic [prod_w(W)-1:0] mul_res_i,
   input  logic                 mul_done_i
);

   localparam int              PW      = prod_w(W);
   localparam int              IW      = idx_w(N);
   localparam int              WDW     = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

   state_e         state_q, state_d;
   logic [IW-1:0]  ptr_q;
   logic [IW-1:0]  gnt_idx_q;
   logic [W-1:0]   a_q, b_q;
   logic [PW-1:0]  res_q;
   logic           err_q;
   logic           done_q;
   logic [WDW-1:0] wdog_q;

   logic [N-1:0]   pick_gnt;
   logic [IW-1:0]  pick_idx;
   logic           pick_any;
   logic           done_edge;
   logic           wd_expired;
   logic [W-1:0]   a_arr [N];
   logic [W-1:0]   b_arr [N];

   // Split the packed operand buses into per-requester lanes.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign a_arr[gi] = req_a_i[gi*W +: W];
      assign b_arr[gi] = req_b_i[gi*W +: W];
   end

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Only a fresh rising edge counts as completion. A done level left high
   // by the previous operation must not finish the current one.
   assign done_edge  = mul_done_i & ~done_q;
   assign wd_expired = (wdog_q == WD_LAST);

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (done_edge || wd_expired) state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath registers: grant latch, watchdog, result capture, and pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q     <= '0;
         gnt_idx_q <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         wdog_q    <= '0;
      end else begin
         // done_q follows mul_done in every state so that an edge that occurs
         // outside WAIT is consumed there.
         done_q <= mul_done_i;
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  gnt_idx_q <= pick_idx;
                  a_q       <= a_arr[pick_idx];
                  b_q       <= b_arr[pick_idx];
               end
            end
            ST_ISSUE: begin
               wdog_q <= '0;
            end
            ST_WAIT: begin
               // When the edge and the expiry fall in the same cycle, the
               // edge wins because it is tested first.
               if (done_edge) begin
                  res_q <= mul_res_i;
                  err_q <= 1'b0;
               end else if (wd_expired) begin
                  res_q <= '0;
                  err_q <= 1'b1;
               end else begin
                  wdog_q <= wdog_q + WDW'(1);
               end
            end
            ST_RESP: begin
               ptr_q <= (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + IW'(1);
            end
            default: ;
         endcase
      end
   end

   // Output decode
   always_comb begin
      req_ready_o  = '0;
      resp_valid_o = '0;
      resp_res_o   = '0;
      resp_err_o   = 1'b0;
      mul_start_o  = 1'b0;
      mul_a_o      = '0;
      mul_b_o      = '0;
      busy_o       = (state_q != ST_IDLE);
      case (state_q)
         // req_ready is combinational from req_valid. It is also masked while
         // reset is asserted, so that all outputs stay at zero during reset.
         ST_IDLE: if (!rst_i) req_ready_o = pick_gnt;
         ST_ISSUE: begin
            mul_start_o = 1'b1;
            mul_a_o     = a_q;
            mul_b_o     = b_q;
         end
         ST_WAIT: begin
            mul_a_o = a_q;
            mul_b_o = b_q;
         end
         ST_RESP: begin
            resp_valid_o[gnt_idx_q] = 1'b1;
            resp_res_o              = res_q;
            resp_err_o              = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_booth_mul_sched.sv
module tb_booth_mul_sched;

   localparam int N       = 4;
   localparam int W       = 4;
   localparam int TIMEOUT = 32;
   localparam int LAT     = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [N-1:0]   req_ready, resp_valid;
   logic [2*W-1:0] resp_res;
   logic           resp_err, busy;
   logic [W-1:0]   mul_a, mul_b;
   logic           mul_start;
   logic [2*W-1:0] mul_res;
   logic           mul_done;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int ready_cnt = 0;
   int resp_cnt = 0;
   int mmode = 0;   // 0 pulse done, 1 never done, 2 level done

   always #5 clk = ~clk;

   booth_mul_sched #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .req_ready_o  (req_ready),
      .resp_valid_o (resp_valid),
      .resp_res_o   (resp_res),
      .resp_err_o   (resp_err),
      .busy_o       (busy),
      .mul_a_o      (mul_a),
      .mul_b_o      (mul_b),
      .mul_start_o  (mul_start),
      .mul_res_i    (mul_res),
      .mul_done_i   (mul_done)
   );

   // Behavioural multiplier: LAT cycles after start it delivers the signed product.
   logic [W-1:0]          pa, pb;
   logic signed [2*W-1:0] pa_x, pb_x, prod;
   int                    mcnt;
   assign pa_x = {{W{pa[W-1]}}, pa};
   assign pb_x = {{W{pb[W-1]}}, pb};
   assign prod = pa_x * pb_x;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_done <= 1'b0; mul_res <= '0; mcnt <= 0; pa <= '0; pb <= '0;
      end else if (mul_start) begin
         pa <= mul_a; pb <= mul_b; mcnt <= LAT;
         if (mmode == 0) mul_done <= 1'b0;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mmode == 0 && mcnt == 1) begin
            mul_done <= 1'b1; mul_res <= prod;
         end else if (mmode == 2 && mcnt == 2) begin
            mul_done <= 1'b0;
         end else if (mmode == 2 && mcnt == 1) begin
            mul_done <= 1'b1; mul_res <= prod;
         end
      end else if (mmode == 0) begin
         mul_done <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mul_start) start_cnt++;
      if (req_ready != '0) ready_cnt++;
      if (resp_valid != '0) resp_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
   endtask

   // Steps until a response strobe appears (or the budget runs out).
   task automatic wait_resp(input int max_cyc, output logic found, output logic [N-1:0] rv,
                            output logic [2*W-1:0] res, output logic e, output int cyc);
      found = 1'b0; rv = '0; res = '0; e = 1'b0; cyc = 0;
      while (!found && cyc < max_cyc) begin
         step();
         cyc++;
         if (resp_valid != '0) begin
            found = 1'b1; rv = resp_valid; res = resp_res; e = resp_err;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 4'hF; req_a = 16'h1234; req_b = 16'h5678;
      step(); step();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b expected 0", mul_start); end
      checks++; if ({mul_a, mul_b} !== 8'h00) begin errors++; $display("FAIL reset_mul_ops: got %h expected 00", {mul_a, mul_b}); end
      checks++; if ({resp_err, resp_res} !== 9'h000) begin errors++; $display("FAIL reset_resp_data: got %h expected 000", {resp_err, resp_res}); end
      req_valid = '0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      int s_start, s_ready, cyc;
      logic found, e;
      logic [N-1:0] rv;
      logic [2*W-1:0] res;
      s_start = start_cnt; s_ready = ready_cnt;
      set_ops(0, 4'h5, 4'hA);             // 5 * -6
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
      step();
      req_valid = '0;
      checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", mul_start); end
      checks++; if ({mul_a, mul_b} !== 8'h5A) begin errors++; $display("FAIL single_mul_ops: got %h expected 5a", {mul_a, mul_b}); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
      wait_resp(20, found, rv, res, e, cyc);
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL single_resp_seen: got %b expected 1", found); end
      checks++; if (rv !== 4'b0001) begin errors++; $display("FAIL single_resp_valid: got %b expected 0001", rv); end
      checks++; if (res !== 8'hE2) begin errors++; $display("FAIL single_res: got %h expected e2", res); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", e); end
      checks++; if (cyc != LAT + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", cyc, LAT + 2); end
      step();
      checks++; if (start_cnt - s_start != 1) begin errors++; $display("FAIL single_start_count: got %0d expected 1", start_cnt - s_start); end
      checks++; if (ready_cnt - s_ready != 1) begin errors++; $display("FAIL single_ready_count: got %0d expected 1", ready_cnt - s_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: got %b expected 0", busy); end
   endtask

   task automatic test_round_robin();
      logic [2*W-1:0] exp_res [4] = '{8'h06, 8'h07, 8'h15, 8'hE2};
      logic [N-1:0] oh, rv;
      logic [2*W-1:0] res;
      logic found, e;
      int cyc;
      do_reset();
      set_ops(0, 4'hD, 4'hE);   // -3 * -2
      set_ops(1, 4'h9, 4'hF);   // -7 * -1
      set_ops(2, 4'hD, 4'h9);   // -3 * -7
      set_ops(3, 4'h5, 4'hA);   //  5 * -6
      req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         oh = 4'b0001 << k;
         #1;
         checks++; if (req_ready !== oh) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, oh); end
         step();
         req_valid[k] = 1'b0;
         wait_resp(20, found, rv, res, e, cyc);
         checks++; if (rv !== oh) begin errors++; $display("FAIL rr_resp_valid%0d: got %b expected %b", k, rv, oh); end
         checks++; if (res !== exp_res[k] || e !== 1'b0) begin errors++; $display("FAIL rr_res%0d: got %h err %b expected %h err 0", k, res, e, exp_res[k]); end
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_no_grant_in_resp%0d: got %b expected 0000", k, req_ready); end
         step();
      end
   endtask

   task automatic test_fairness();
      int exp_g [6] = '{0, 2, 0, 2, 3, 0};
      logic [2*W-1:0] exp_res [6] = '{8'h06, 8'h01, 8'h06, 8'h01, 8'h40, 8'h06};
      logic [N-1:0] oh, rv;
      logic [2*W-1:0] res;
      logic found, e;
      int cyc;
      set_ops(0, 4'h2, 4'h3);   //  2 *  3
      set_ops(2, 4'hF, 4'hF);   // -1 * -1
      set_ops(3, 4'h8, 4'h8);   // -8 * -8
      for (int k = 0; k < 6; k++) begin
         req_valid = (k < 4) ? 4'b0101 : 4'b1001;
         oh = 4'b0001 << exp_g[k];
         #1;
         checks++; if (req_ready !== oh) begin errors++; $display("FAIL fair_grant%0d: got %b expected %b", k, req_ready, oh); end
         step();
         wait_resp(20, found, rv, res, e, cyc);
         checks++; if (rv !== oh || res !== exp_res[k]) begin errors++; $display("FAIL fair_resp%0d: got %b/%h expected %b/%h", k, rv, res, oh, exp_res[k]); end
         step();
      end
      req_valid = '0;
   endtask

   task automatic test_timeout();
      logic [N-1:0] rv;
      logic [2*W-1:0] res;
      logic found, e;
      int cyc;
      mmode = 1;
      set_ops(1, 4'h3, 4'h3);
      req_valid = 4'b0010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_grant: got %b expected 0010", req_ready); end
      step();
      req_valid = '0;
      wait_resp(TIMEOUT + 10, found, rv, res, e, cyc);
      checks++; if (rv !== 4'b0010) begin errors++; $display("FAIL to_resp_valid: got %b expected 0010", rv); end
      checks++; if (e !== 1'b1 || res !== 8'h00) begin errors++; $display("FAIL to_err: got err %b res %h expected err 1 res 00", e, res); end
      checks++; if (cyc != TIMEOUT + 1) begin errors++; $display("FAIL to_latency: got %0d expected %0d", cyc, TIMEOUT + 1); end
      step();
      mmode = 0;
      set_ops(2, 4'h8, 4'h7);   // -8 * 7
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_next_grant: got %b expected 0100", req_ready); end
      step();
      req_valid = '0;
      wait_resp(20, found, rv, res, e, cyc);
      checks++; if (rv !== 4'b0100 || res !== 8'hC8 || e !== 1'b0) begin errors++; $display("FAIL to_next_resp: got %b/%h/%b expected 0100/c8/0", rv, res, e); end
      checks++; if (cyc != LAT + 2) begin errors++; $display("FAIL to_next_latency: got %0d expected %0d", cyc, LAT + 2); end
      step();
   endtask

   task automatic test_level_done();
      logic [N-1:0] rv;
      logic [2*W-1:0] res;
      logic found, e;
      int cyc;
      mmode = 2;
      set_ops(3, 4'h7, 4'h7);   // 7 * 7
      req_valid = 4'b1000;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lvl_grant1: got %b expected 1000", req_ready); end
      step();
      req_valid = '0;
      wait_resp(20, found, rv, res, e, cyc);
      checks++; if (rv !== 4'b1000 || res !== 8'h31) begin errors++; $display("FAIL lvl_resp1: got %b/%h expected 1000/31", rv, res); end
      step();
      set_ops(0, 4'h8, 4'h1);   // -8 * 1
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lvl_grant2: got %b expected 0001", req_ready); end
      step();
      req_valid = '0;
      wait_resp(20, found, rv, res, e, cyc);
      checks++; if (cyc != LAT + 2) begin errors++; $display("FAIL lvl_no_early: got %0d cycles expected %0d", cyc, LAT + 2); end
      checks++; if (rv !== 4'b0001 || res !== 8'hF8 || e !== 1'b0) begin errors++; $display("FAIL lvl_resp2: got %b/%h/%b expected 0001/f8/0", rv, res, e); end
      step();
      mmode = 0;
   endtask

   task automatic test_reset_mid_op();
      logic [N-1:0] rv;
      logic [2*W-1:0] res;
      logic found, e;
      int cyc, s_resp;
      s_resp = resp_cnt;
      set_ops(1, 4'h2, 4'hD);   // 2 * -3
      req_valid = 4'b0010;
      step();                   // ISSUE
      req_valid = '0;
      step();                   // WAIT
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b expected 1", busy); end
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy %b start %b expected 0 0", busy, mul_start); end
      checks++; if ({mul_a, mul_b} !== 8'h00) begin errors++; $display("FAIL rst_mid_ops: got %h expected 00", {mul_a, mul_b}); end
      checks++; if (resp_valid !== 4'b0000 || {resp_err, resp_res} !== 9'h000) begin errors++; $display("FAIL rst_mid_resp: got %b/%h expected 0000/000", resp_valid, {resp_err, resp_res}); end
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step();
      checks++; if (resp_cnt != s_resp) begin errors++; $display("FAIL rst_no_resp: got %0d strobes expected 0", resp_cnt - s_resp); end
      // Pointer is back at 0, so requester 0 wins over requester 1.
      set_ops(0, 4'h2, 4'hD);
      req_valid = 4'b0011;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_after_grant: got %b expected 0001", req_ready); end
      step();
      req_valid = '0;
      wait_resp(20, found, rv, res, e, cyc);
      checks++; if (rv !== 4'b0001 || res !== 8'hFA || e !== 1'b0) begin errors++; $display("FAIL rst_after_resp: got %b/%h/%b expected 0001/fa/0", rv, res, e); end
      step();
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_timeout();
      test_level_done();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
